// File: rtl/bist_misr_checker.sv
// Response-side BIST checker: compacts CUT responses into a Galois MISR signature
// and reports pass/fail against a golden signature sampled at run start.
module bist_misr_checker #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_RESP = 8,
  parameter logic [DATA_W-1:0] POLY     = 32'h04C11DB7,
  parameter logic [DATA_W-1:0] SEED     = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_val,
  output logic              start_rdy,
  input  logic [DATA_W-1:0] expected_sig,
  input  logic              resp_val,
  output logic              resp_rdy,
  input  logic [DATA_W-1:0] resp_msg,
  output logic              result_val,
  input  logic              result_rdy,
  output logic              result_pass,
  output logic [DATA_W-1:0] result_sig
);

  localparam int               CNT_W = $clog2(NUM_RESP + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_RESP - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] sig;
  logic [DATA_W-1:0] exp_sig;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] sig_next;
  logic              start_fire;
  logic              resp_fire;
  logic              result_fire;

  // One MISR step: multiply by x modulo POLY, then fold in the new response.
  function automatic logic [DATA_W-1:0] misr_step(input logic [DATA_W-1:0] s,
                                                  input logic [DATA_W-1:0] d);
    misr_step = {s[DATA_W-2:0], 1'b0} ^ (s[DATA_W-1] ? POLY : '0) ^ d;
  endfunction

  assign start_fire  = start_val && start_rdy;
  assign resp_fire   = resp_val && resp_rdy;
  assign result_fire = result_val && result_rdy;
  assign sig_next    = misr_step(sig, resp_msg);
  assign result_sig  = sig;

  // Handshake flags are registered with the state so they change only on clock edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sig         <= SEED;
      exp_sig     <= '0;
      count       <= '0;
      start_rdy   <= 1'b1;
      resp_rdy    <= 1'b0;
      result_val  <= 1'b0;
      result_pass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fire) begin
            sig       <= SEED;
            exp_sig   <= expected_sig;
            count     <= '0;
            state     <= COLLECT;
            start_rdy <= 1'b0;
            resp_rdy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (resp_fire) begin
            sig   <= sig_next;
            count <= count + 1'b1;
            if (count == LAST) begin
              // Final response is folded in on this edge, so compare the updated value.
              state       <= DONE;
              resp_rdy    <= 1'b0;
              result_val  <= 1'b1;
              result_pass <= (sig_next == exp_sig);
            end
          end
        end
        DONE: begin
          if (result_fire) begin
            state       <= IDLE;
            result_val  <= 1'b0;
            result_pass <= 1'b0;
            start_rdy   <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          start_rdy   <= 1'b1;
          resp_rdy    <= 1'b0;
          result_val  <= 1'b0;
          result_pass <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Bench for bist_misr_checker: a small 8-bit instance for directed cases and a
// default 32-bit instance for randomized runs, both checked against a polynomial model.
module tb_bist_misr_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       s_start_val, s_start_rdy, s_resp_val, s_resp_rdy;
  logic       s_result_val, s_result_rdy, s_result_pass;
  logic [7:0] s_expected_sig, s_resp_msg, s_result_sig;

  logic        d_start_val, d_start_rdy, d_resp_val, d_resp_rdy;
  logic        d_result_val, d_result_rdy, d_result_pass;
  logic [31:0] d_expected_sig, d_resp_msg, d_result_sig;

  int checks = 0;
  int errors = 0;

  bist_misr_checker #(.DATA_W(8), .NUM_RESP(2), .POLY(8'h1D), .SEED(8'h00)) dut_s (
    .clk(clk), .reset(reset),
    .start_val(s_start_val), .start_rdy(s_start_rdy), .expected_sig(s_expected_sig),
    .resp_val(s_resp_val), .resp_rdy(s_resp_rdy), .resp_msg(s_resp_msg),
    .result_val(s_result_val), .result_rdy(s_result_rdy),
    .result_pass(s_result_pass), .result_sig(s_result_sig)
  );

  bist_misr_checker dut_d (
    .clk(clk), .reset(reset),
    .start_val(d_start_val), .start_rdy(d_start_rdy), .expected_sig(d_expected_sig),
    .resp_val(d_resp_val), .resp_rdy(d_resp_rdy), .resp_msg(d_resp_msg),
    .result_val(d_result_val), .result_rdy(d_result_rdy),
    .result_pass(d_result_pass), .result_sig(d_result_sig)
  );

  // Signature as polynomial arithmetic over GF(2): s = s*x mod (x^w + poly) + r.
  function automatic logic [31:0] model(input int w, input logic [31:0] poly,
                                        input logic [31:0] seed, input logic [31:0] r[$]);
    longint unsigned s, top;
    s   = 64'(seed);
    top = 64'd1 << w;
    foreach (r[i]) begin
      s = s << 1;
      if ((s & top) != 0) s = s ^ top ^ 64'(poly);
      s = s ^ 64'(r[i]);
    end
    return s[31:0];
  endfunction

  function automatic logic [7:0] smodel(input logic [31:0] r[$]);
    logic [31:0] v;
    v = model(8, 32'h1D, 32'h00, r);
    return v[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_start(input logic [7:0] e);
    s_expected_sig = e;
    s_start_val    = 1'b1;
    tick();
    s_start_val    = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] d);
    int n = 0;
    s_resp_msg = d;
    s_resp_val = 1'b1;
    while (!s_resp_rdy && n < 20) begin tick(); n++; end
    if (!s_resp_rdy) begin
      checks++; errors++;
      $display("FAIL s_resp_rdy_timeout: resp_rdy=%0b required 1", s_resp_rdy);
    end
    tick();
    s_resp_val = 1'b0;
  endtask

  task automatic s_take(output logic p, output logic [7:0] sg);
    int n = 0;
    while (!s_result_val && n < 20) begin tick(); n++; end
    if (!s_result_val) begin
      checks++; errors++;
      $display("FAIL s_result_timeout: result_val=%0b required 1", s_result_val);
    end
    p  = s_result_pass;
    sg = s_result_sig;
    s_result_rdy = 1'b1;
    tick();
    s_result_rdy = 1'b0;
  endtask

  task automatic d_run(input logic [31:0] e, input logic [31:0] r[$],
                       output logic p, output logic [31:0] sg);
    int n = 0;
    d_expected_sig = e;
    d_start_val    = 1'b1;
    while (!d_start_rdy && n < 20) begin tick(); n++; end
    tick();
    d_start_val    = 1'b0;
    d_expected_sig = $urandom;
    foreach (r[i]) begin
      repeat ($urandom_range(0, 3)) begin
        d_resp_msg = $urandom;
        tick();
      end
      d_resp_msg = r[i];
      d_resp_val = 1'b1;
      n = 0;
      while (!d_resp_rdy && n < 20) begin tick(); n++; end
      tick();
      d_resp_val = 1'b0;
    end
    n = 0;
    while (!d_result_val && n < 20) begin tick(); n++; end
    if (!d_result_val) begin
      checks++; errors++;
      $display("FAIL d_result_timeout: result_val=%0b required 1", d_result_val);
    end
    p  = d_result_pass;
    sg = d_result_sig;
    d_result_rdy = 1'b1;
    tick();
    d_result_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (s_start_rdy !== 1'b1) begin errors++; $display("FAIL reset_start_rdy: got %0b want 1", s_start_rdy); end
    checks++; if (s_resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy: got %0b want 0", s_resp_rdy); end
    checks++; if (s_result_val !== 1'b0) begin errors++; $display("FAIL reset_result_val: got %0b want 0", s_result_val); end
    checks++; if (s_result_pass !== 1'b0) begin errors++; $display("FAIL reset_result_pass: got %0b want 0", s_result_pass); end
    checks++; if (s_result_sig !== 8'h00) begin errors++; $display("FAIL reset_s_sig: got %h want 00", s_result_sig); end
    checks++; if (d_result_sig !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_d_sig: got %h want ffffffff", d_result_sig); end
    checks++; if (d_start_rdy !== 1'b1) begin errors++; $display("FAIL reset_d_start_rdy: got %0b want 1", d_start_rdy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] q[$];
    logic [7:0]  m;
    q = {32'h01};
    s_start(8'h00);
    checks++; if (s_start_rdy !== 1'b0 || s_resp_rdy !== 1'b1) begin errors++; $display("FAIL basic_collect_rdys: got start=%0b resp=%0b want 0/1", s_start_rdy, s_resp_rdy); end
    s_send(8'h01);
    m = smodel(q);
    checks++; if (s_result_sig !== m) begin errors++; $display("FAIL basic_mid_sig: got %h want %h", s_result_sig, m); end
    s_send(8'h02);
    q.push_back(32'h02);
    m = smodel(q);
    checks++; if (s_result_val !== 1'b1) begin errors++; $display("FAIL basic_latency: result_val=%0b want 1", s_result_val); end
    checks++; if (s_result_sig !== m) begin errors++; $display("FAIL basic_final_sig: got %h want %h", s_result_sig, m); end
    checks++; if (s_result_pass !== (m == 8'h00)) begin errors++; $display("FAIL basic_pass: got %0b want %0b", s_result_pass, m == 8'h00); end
    s_result_rdy = 1'b1;
    tick();
    s_result_rdy = 1'b0;
    checks++; if (s_result_val !== 1'b0 || s_start_rdy !== 1'b1) begin errors++; $display("FAIL basic_return_idle: got val=%0b start_rdy=%0b want 0/1", s_result_val, s_start_rdy); end
  endtask

  task automatic test_feedback();
    logic [31:0] q[$];
    logic [7:0]  m, sg;
    logic        p;
    q = {32'h80, 32'h00};
    m = smodel(q);
    s_start(8'h1D);
    s_send(8'h80);
    checks++; if (s_result_sig !== 8'h80) begin errors++; $display("FAIL feedback_mid_sig: got %h want 80", s_result_sig); end
    s_send(8'h00);
    s_take(p, sg);
    checks++; if (sg !== m) begin errors++; $display("FAIL feedback_sig: got %h want %h", sg, m); end
    checks++; if (p !== (m == 8'h1D)) begin errors++; $display("FAIL feedback_pass: got %0b want %0b", p, m == 8'h1D); end
    s_start(8'h1C);
    s_send(8'h80);
    s_send(8'h00);
    s_take(p, sg);
    checks++; if (p !== (m == 8'h1C)) begin errors++; $display("FAIL feedback_mismatch_pass: got %0b want %0b", p, m == 8'h1C); end
  endtask

  task automatic test_stall();
    s_start(8'h00);
    s_send(8'h01);
    for (int i = 0; i < 3; i++) begin
      s_resp_msg = 8'hA5;
      tick();
      checks++; if (s_result_sig !== 8'h01 || s_result_val !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: sig=%h val=%0b want 01/0", i, s_result_sig, s_result_val); end
    end
    s_send(8'h02);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s_result_val !== 1'b1 || s_result_pass !== 1'b1 || s_result_sig !== 8'h00 || s_start_rdy !== 1'b0) begin
        errors++; $display("FAIL result_hold_%0d: val=%0b pass=%0b sig=%h start_rdy=%0b want 1/1/00/0", i, s_result_val, s_result_pass, s_result_sig, s_start_rdy);
      end
    end
    s_result_rdy = 1'b1;
    tick();
    s_result_rdy = 1'b0;
  endtask

  task automatic test_guards();
    logic [7:0] sg;
    logic       p;
    s_resp_val = 1'b1;
    s_resp_msg = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_resp_rdy !== 1'b0 || s_result_sig !== 8'h00) begin errors++; $display("FAIL idle_resp_ignored_%0d: rdy=%0b sig=%h want 0/00", i, s_resp_rdy, s_result_sig); end
    end
    s_resp_val = 1'b0;
    s_start(8'h00);
    s_expected_sig = 8'hFF;
    s_start_val    = 1'b1;
    s_send(8'h01);
    checks++; if (s_start_rdy !== 1'b0 || s_result_sig !== 8'h01) begin errors++; $display("FAIL collect_start_ignored: start_rdy=%0b sig=%h want 0/01", s_start_rdy, s_result_sig); end
    s_send(8'h02);
    s_start_val = 1'b0;
    s_take(p, sg);
    checks++; if (p !== 1'b1 || sg !== 8'h00) begin errors++; $display("FAIL sampled_expected: pass=%0b sig=%h want 1/00", p, sg); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] sg;
    logic       p;
    s_start(8'h00);
    s_send(8'h01);
    #2 reset = 1'b1;
    #1;
    checks++; if (s_start_rdy !== 1'b1 || s_resp_rdy !== 1'b0 || s_result_val !== 1'b0 || s_result_sig !== 8'h00) begin
      errors++; $display("FAIL async_reset: start_rdy=%0b resp_rdy=%0b val=%0b sig=%h want 1/0/0/00", s_start_rdy, s_resp_rdy, s_result_val, s_result_sig);
    end
    #1 reset = 1'b0;
    tick();
    checks++; if (s_result_val !== 1'b0 || s_start_rdy !== 1'b1) begin errors++; $display("FAIL reset_no_result: val=%0b start_rdy=%0b want 0/1", s_result_val, s_start_rdy); end
    s_start(8'h1D);
    s_send(8'h80);
    s_send(8'h00);
    s_take(p, sg);
    checks++; if (p !== 1'b1 || sg !== 8'h1D) begin errors++; $display("FAIL fresh_run: pass=%0b sig=%h want 1/1d", p, sg); end
  endtask

  task automatic test_default();
    logic [31:0] r[$], rf[$];
    logic [31:0] e, ef, sg;
    logic        p;
    for (int i = 0; i < 8; i++) r.push_back($urandom);
    e = model(32, 32'h04C11DB7, 32'hFFFF_FFFF, r);
    d_run(e, r, p, sg);
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL default_pass: got %0b want 1", p); end
    checks++; if (sg !== e) begin errors++; $display("FAIL default_sig: got %h want %h", sg, e); end
    rf = r;
    rf[5] = rf[5] ^ (32'h1 << $urandom_range(0, 31));
    ef = model(32, 32'h04C11DB7, 32'hFFFF_FFFF, rf);
    d_run(e, rf, p, sg);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL default_flip_pass: got %0b want 0", p); end
    checks++; if (sg !== ef) begin errors++; $display("FAIL default_flip_sig: got %h want %h", sg, ef); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r[$];
    logic [31:0] e;
    d_start_val  = 1'b1;
    d_resp_val   = 1'b1;
    d_result_rdy = 1'b1;
    for (int run = 0; run < 2; run++) begin
      r = {};
      for (int i = 0; i < 8; i++) r.push_back($urandom);
      e = model(32, 32'h04C11DB7, 32'hFFFF_FFFF, r);
      d_expected_sig = (run == 0) ? e : (e ^ 32'h1);
      checks++; if (d_start_rdy !== 1'b1) begin errors++; $display("FAIL b2b_start_rdy_%0d: got %0b want 1", run, d_start_rdy); end
      tick();
      foreach (r[i]) begin
        d_resp_msg = r[i];
        tick();
      end
      checks++; if (d_result_val !== 1'b1 || d_start_rdy !== 1'b0) begin errors++; $display("FAIL b2b_latency_%0d: val=%0b start_rdy=%0b want 1/0", run, d_result_val, d_start_rdy); end
      checks++; if (d_result_sig !== e || d_result_pass !== (run == 0)) begin
        errors++; $display("FAIL b2b_result_%0d: sig=%h pass=%0b want %h/%0b", run, d_result_sig, d_result_pass, e, run == 0);
      end
      tick();
      checks++; if (d_result_val !== 1'b0 || d_start_rdy !== 1'b1 || d_resp_rdy !== 1'b0) begin
        errors++; $display("FAIL b2b_gap_%0d: val=%0b start_rdy=%0b resp_rdy=%0b want 0/1/0", run, d_result_val, d_start_rdy, d_resp_rdy);
      end
    end
    d_start_val  = 1'b0;
    d_resp_val   = 1'b0;
    d_result_rdy = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_start_val = 1'b0; s_resp_val = 1'b0; s_result_rdy = 1'b0;
    s_expected_sig = '0; s_resp_msg = '0;
    d_start_val = 1'b0; d_resp_val = 1'b0; d_result_rdy = 1'b0;
    d_expected_sig = '0; d_resp_msg = '0;
    test_reset();
    test_basic();
    test_feedback();
    test_stall();
    test_guards();
    test_reset_mid();
    test_default();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
